// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, register addressing and
// writeback source-select encodings.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // mem_to_reg encodings, shared with the WB stage
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;

endpackage

// File: rtl/reg_scoreboard.sv
// Load-use scoreboard: one busy bit per register, set on load issue, cleared on
// writeback commit or flush, with the busy lookups masked for a retiring producer.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_reg_write_en,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  ld_issue_en,
    input  logic [REG_ADDR_W-1:0] ld_rd_addr,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;

    // Next busy vector: clear the retiring register first so a same-address issue wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wb_reg_write_en) begin
            busy_nxt_s[wb_rd_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (ld_issue_en && (ld_rd_addr != REG_ZERO)) begin
            busy_nxt_s[ld_rd_addr] = 1'b1;
        end else begin
            busy_nxt_s[0] = busy_nxt_s[0];
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Busy register: flush outranks any issue in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= '0;
        end else if (flush) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Busy lookups, hidden when the producer retires this cycle.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rs1_addr != REG_ZERO) begin
            rs1_busy = busy_r[rs1_addr] & ~(wb_reg_write_en & (wb_rd_addr == rs1_addr));
        end else begin
            rs1_busy = 1'b0;
        end
        if (rs2_addr != REG_ZERO) begin
            rs2_busy = busy_r[rs2_addr] & ~(wb_reg_write_en & (wb_rd_addr == rs2_addr));
        end else begin
            rs2_busy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: x1-x31 storage, two combinational read ports with
// writeback bypass, and the load-use scoreboard for ID stalls.
module reg_file #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wb_reg_write_en,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]                  wb_data,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] rs1_addr,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]                  rs1_data,
    output logic [XLEN-1:0]                  rs2_data,
    input  logic                             ld_issue_en,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] ld_rd_addr,
    input  logic                             flush,
    output logic                             rs1_busy,
    output logic                             rs2_busy
);

    import riscv_pkg::REG_ZERO;

    // x0 has no storage; it reads as constant zero.
    logic [XLEN-1:0] regs_r [1:NREGS-1];
    logic            wr_hit_s;

    assign wr_hit_s = wb_reg_write_en && (wb_rd_addr != REG_ZERO);

    // Register array write; reset clears every stored register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_hit_s) begin
            regs_r[wb_rd_addr] <= wb_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Read ports: x0 is zero, a same-cycle writeback to the address is forwarded.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr == REG_ZERO) begin
            rs1_data = '0;
        end else if (wr_hit_s && (wb_rd_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_r[rs1_addr];
        end
        if (rs2_addr == REG_ZERO) begin
            rs2_data = '0;
        end else if (wr_hit_s && (wb_rd_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_r[rs2_addr];
        end
    end

    reg_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .wb_reg_write_en(wb_reg_write_en),
        .wb_rd_addr     (wb_rd_addr),
        .ld_issue_en    (ld_issue_en),
        .ld_rd_addr     (ld_rd_addr),
        .flush          (flush),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected read-port values are queued as each
// step is driven and popped and compared just before the next rising edge.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_write_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ld_issue_en;
    logic [4:0]  ld_rd_addr;
    logic        flush;
    logic        rs1_busy;
    logic        rs2_busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    reg_file dut (
        .clk            (clk),
        .rst            (rst),
        .wb_reg_write_en(wb_reg_write_en),
        .wb_rd_addr     (wb_rd_addr),
        .wb_data        (wb_data),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .ld_issue_en    (ld_issue_en),
        .ld_rd_addr     (ld_rd_addr),
        .flush          (flush),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy)
    );

    // One cycle: drive at negedge, queue expectation, compare before posedge, advance.
    task automatic step(input string tag,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic li, input logic [4:0] la, input logic fl, input logic rs,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic eb1, input logic eb2);
        exp_t e;
        wb_reg_write_en = we;
        wb_rd_addr      = wa;
        wb_data         = wd;
        rs1_addr        = a1;
        rs2_addr        = a2;
        ld_issue_en     = li;
        ld_rd_addr      = la;
        flush           = fl;
        rst             = rs;
        exp_q.push_back('{tag, e1, e2, eb1, eb2});
        #2;
        e = exp_q.pop_front();
        vectors++;
        assert (rs1_data === e.d1) else begin
            miscompares++;
            $error("FAIL %s rs1_data got %h expected %h", e.tag, rs1_data, e.d1);
        end
        assert (rs2_data === e.d2) else begin
            miscompares++;
            $error("FAIL %s rs2_data got %h expected %h", e.tag, rs2_data, e.d2);
        end
        assert (rs1_busy === e.b1) else begin
            miscompares++;
            $error("FAIL %s rs1_busy got %b expected %b", e.tag, rs1_busy, e.b1);
        end
        assert (rs2_busy === e.b2) else begin
            miscompares++;
            $error("FAIL %s rs2_busy got %b expected %b", e.tag, rs2_busy, e.b2);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wb_reg_write_en = 1'b0; wb_rd_addr = 5'd0; wb_data = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; ld_issue_en = 1'b0; ld_rd_addr = 5'd0;
        flush = 1'b0;
        @(negedge clk);

        //   tag             we    wa     wd            a1     a2     li    la     fl    rs    e1            e2            b1    b2
        step("reset_read",   1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("wr_x5",        1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd31, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("rd_x5",        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
        step("wr_x0_same",   1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
        step("wr_x0_later",  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("wr_x7_init",   1'b1, 5'd7,  32'h1,        5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("rd_x7_old",    1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 1'b0, 32'h1,        32'h1,        1'b0, 1'b0);
        step("bypass_x7",    1'b1, 5'd7,  32'hCAFEF00D, 5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0);
        step("array_x7",     1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  1'b0, 5'd0,  1'b0, 1'b0, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0);
        step("ld_x9_issue",  1'b0, 5'd0,  32'h0,        5'd0,  5'd9,  1'b1, 5'd9,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("ld_x9_busy",   1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1);
        step("wb_x9_retire", 1'b1, 5'd9,  32'h55,       5'd0,  5'd9,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h55,       1'b0, 1'b0);
        step("x9_cleared",   1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  1'b0, 5'd0,  1'b0, 1'b0, 32'h55,       32'h55,       1'b0, 1'b0);
        step("ld_x0_issue",  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("x0_never_bsy", 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("set_clr_x3",   1'b1, 5'd3,  32'hAA,       5'd3,  5'd4,  1'b1, 5'd3,  1'b0, 1'b0, 32'hAA,       32'h0,        1'b0, 1'b0);
        step("x3_set_wins",  1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  1'b0, 5'd0,  1'b0, 1'b0, 32'hAA,       32'h0,        1'b1, 1'b0);
        step("ld4_clr3",     1'b1, 5'd3,  32'hBB,       5'd3,  5'd4,  1'b1, 5'd4,  1'b0, 1'b0, 32'hBB,       32'h0,        1'b0, 1'b0);
        step("ld3_again",    1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  1'b1, 5'd3,  1'b0, 1'b0, 32'hBB,       32'h0,        1'b0, 1'b1);
        step("flush_ld4",    1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  1'b1, 5'd4,  1'b1, 1'b0, 32'hBB,       32'h0,        1'b1, 1'b1);
        step("post_flush",   1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  1'b0, 5'd0,  1'b0, 1'b0, 32'hBB,       32'h0,        1'b0, 1'b0);
        step("flush_ld10",   1'b0, 5'd0,  32'h0,        5'd10, 5'd3,  1'b1, 5'd10, 1'b1, 1'b0, 32'h0,        32'hBB,       1'b0, 1'b0);
        step("x10_not_bsy",  1'b0, 5'd0,  32'h0,        5'd10, 5'd3,  1'b1, 5'd11, 1'b0, 1'b0, 32'h0,        32'hBB,       1'b0, 1'b0);
        step("rst_midrun",   1'b1, 5'd12, 32'h77,       5'd3,  5'd11, 1'b1, 5'd13, 1'b0, 1'b1, 32'hBB,       32'h0,        1'b0, 1'b1);
        step("post_rst_a",   1'b0, 5'd0,  32'h0,        5'd3,  5'd12, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("post_rst_b",   1'b0, 5'd0,  32'h0,        5'd11, 5'd13, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step("post_rst_c",   1'b0, 5'd0,  32'h0,        5'd5,  5'd9,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
